// File: rtl/mux_2to1_if.sv
// Select/operand/result bundle for mux_2to1.
// The master drives sel, a and b. The slave returns y.
interface mux_2to1_if #(
    parameter int unsigned N = 4
);
    logic         sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] y;

    modport master (output sel, output a, output b, input y);
    modport slave  (input sel, input a, input b, output y);
endinterface

// File: rtl/mux_2to1_dff_arn.sv
// N-bit register that resets asynchronously to zero when rst_n is low.
module dff_arn #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/mux_2to1.sv
// Two-way N-bit selector. REG_OUT=1 gives a registered output with an async-clear register.
// REG_OUT=0 gives a purely combinational output.
module mux_2to1 #(
    parameter int unsigned N       = 4,
    parameter bit          REG_OUT = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    mux_2to1_if.slave   bus
);
    logic [N-1:0] y_next;

    // An unknown select propagates as all-X in simulation
    always_comb begin
        y_next = '0;
        case (bus.sel)
            1'b1:    y_next = bus.a;
            1'b0:    y_next = bus.b;
            default: y_next = 'x;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg
            dff_arn #(
                .N (N)
            ) u_dff (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (y_next),
                .q     (bus.y)
            );
        end else begin : g_comb
            // In this mode clk and rst_n do not affect y
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n};
            assign bus.y     = y_next;
        end
    endgenerate
endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1. It runs a registered N=4 instance, a registered N=16 instance
// and a combinational N=4 instance side by side.
`timescale 1ns/100ps
module tb_mux_2to1;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    mux_2to1_if #(.N(4))  if4 ();
    mux_2to1_if #(.N(16)) if16 ();
    mux_2to1_if #(.N(4))  ifc ();

    mux_2to1 #(.N(4), .REG_OUT(1'b1)) u_reg4 (
        .clk (clk), .rst_n (rst_n), .bus (if4)
    );
    mux_2to1 #(.N(16), .REG_OUT(1'b1)) u_reg16 (
        .clk (clk), .rst_n (rst_n), .bus (if16)
    );
    mux_2to1 #(.N(4), .REG_OUT(1'b0)) u_comb4 (
        .clk (clk), .rst_n (rst_n), .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference selection rule, applied to whole words
    function automatic logic [15:0] pick(input logic s, input logic [15:0] x, input logic [15:0] z);
        return s ? x : z;
    endfunction

    task automatic drive4(input logic s, input logic [3:0] x, input logic [3:0] z);
        if4.sel = s;
        if4.a   = x;
        if4.b   = z;
        ifc.sel = s;
        ifc.a   = x;
        ifc.b   = z;
    endtask

    task automatic test_reset;
        logic [3:0] y_hold;
        drive4(1'b1, 4'hF, 4'hA);
        if16.sel = 1'b1;
        if16.a   = 16'hFFFF;
        if16.b   = 16'hAAAA;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if4.y !== 4'h0) $display("FAIL reset_immediate4 got=%h exp=%h", if4.y, 4'h0);
        else pass_cnt++;
        total_cnt++;
        if (if16.y !== 16'h0) $display("FAIL reset_immediate16 got=%h exp=%h", if16.y, 16'h0);
        else pass_cnt++;
        total_cnt++;
        if (ifc.y !== 4'hF) $display("FAIL reset_comb_unaffected got=%h exp=%h", ifc.y, 4'hF);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        y_hold = if4.y;
        total_cnt++;
        if (y_hold !== 4'h0) $display("FAIL reset_held got=%h exp=%h", y_hold, 4'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (if4.y !== 4'hF) $display("FAIL reset_first_load got=%h exp=%h", if4.y, 4'hF);
        else pass_cnt++;
        total_cnt++;
        if (if16.y !== 16'hFFFF) $display("FAIL reset_first_load16 got=%h exp=%h", if16.y, 16'hFFFF);
        else pass_cnt++;
    endtask

    task automatic test_select_a;
        drive4(1'b1, 4'h3, 4'hC);
        @(negedge clk);
        total_cnt++;
        if (if4.y !== 4'h3) $display("FAIL select_a got=%h exp=%h", if4.y, 4'h3);
        else pass_cnt++;
    endtask

    task automatic test_select_b_toggle;
        logic [3:0] expq[$];
        logic       s;
        s = 1'b0;
        drive4(s, 4'h3, 4'hC);
        expq.push_back(4'(pick(s, 16'h3, 16'hC)));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total_cnt++;
            if (if4.y !== expq[0]) $display("FAIL select_toggle[%0d] got=%h exp=%h", i, if4.y, expq[0]);
            else pass_cnt++;
            void'(expq.pop_front());
            s = ~s;
            drive4(s, 4'h3, 4'hC);
            expq.push_back(4'(pick(s, 16'h3, 16'hC)));
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        drive4(1'b1, 4'h5, 4'h0);
        @(negedge clk);
        total_cnt++;
        if (if4.y !== 4'h5) $display("FAIL midrst_before got=%h exp=%h", if4.y, 4'h5);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if4.y !== 4'h0) $display("FAIL midrst_instant got=%h exp=%h", if4.y, 4'h0);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        drive4(1'b1, 4'h6, 4'h1);
        #1;
        total_cnt++;
        if (if4.y !== 4'h0) $display("FAIL midrst_after_release got=%h exp=%h", if4.y, 4'h0);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (if4.y !== 4'h6) $display("FAIL midrst_reload got=%h exp=%h", if4.y, 4'h6);
        else pass_cnt++;
    endtask

    task automatic test_equal;
        for (int k = 0; k < 2; k++) begin
            drive4(k[0], 4'h9, 4'h9);
            #1;
            total_cnt++;
            if (ifc.y !== 4'h9) $display("FAIL equal_comb sel=%0d got=%h exp=%h", k, ifc.y, 4'h9);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (if4.y !== 4'h9) $display("FAIL equal_reg sel=%0d got=%h exp=%h", k, if4.y, 4'h9);
            else pass_cnt++;
        end
    endtask

    task automatic test_comb;
        @(negedge clk);
        #1 drive4(1'b1, 4'h7, 4'h2);
        #1;
        total_cnt++;
        if (ifc.y !== 4'h7) $display("FAIL comb_sel1 got=%h exp=%h", ifc.y, 4'h7);
        else pass_cnt++;
        ifc.sel = 1'b0;
        #1;
        total_cnt++;
        if (ifc.y !== 4'h2) $display("FAIL comb_sel0 got=%h exp=%h", ifc.y, 4'h2);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic        s;
        logic [3:0]  a4, b4, e4;
        logic [15:0] a16, b16, e16;
        for (int i = 0; i < 1200; i++) begin
            s   = 1'($urandom_range(0, 1));
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            drive4(s, a4, b4);
            if16.sel = s;
            if16.a   = a16;
            if16.b   = b16;
            e4  = 4'(pick(s, 16'(a4), 16'(b4)));
            e16 = pick(s, a16, b16);
            #1;
            total_cnt++;
            if (ifc.y !== e4) $display("FAIL rand_comb[%0d] got=%h exp=%h", i, ifc.y, e4);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (if4.y !== e4) $display("FAIL rand_reg4[%0d] got=%h exp=%h", i, if4.y, e4);
            else pass_cnt++;
            total_cnt++;
            if (if16.y !== e16) $display("FAIL rand_reg16[%0d] got=%h exp=%h", i, if16.y, e16);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b1;
        drive4(1'b0, 4'h0, 4'h0);
        if16.sel = 1'b0;
        if16.a   = '0;
        if16.b   = '0;
        test_reset();
        test_select_a();
        test_select_b_toggle();
        test_mid_reset();
        test_equal();
        test_comb();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
